// File: rtl/fir_pkg.sv
// Shared FIR constants plus the output-stage additions: input word width,
// default decimation, output FIFO depth and the round/saturate reference
// function used by the output stage's reference model.
package fir_pkg;

    localparam int BIT_PREC       = 16;
    localparam int TAPS           = 8;
    localparam int OUT_DECIM_W    = 2*BIT_PREC + TAPS - 1;
    localparam int OUT_FRAC_SHIFT = BIT_PREC - 1;
    localparam int DECIM_DEFAULT  = 4;
    localparam int OUT_FIFO_DEPTH = 4;

    typedef struct packed {
        logic                       sat;
        logic signed [BIT_PREC-1:0] val;
    } sat_round_t;

    // Round half toward +inf, drop the coefficient fraction, clip to BIT_PREC.
    function automatic sat_round_t sat_round(input logic signed [OUT_DECIM_W-1:0] x);
        logic signed [OUT_DECIM_W:0] t;
        logic signed [OUT_DECIM_W:0] q;
        logic signed [OUT_DECIM_W:0] q_max;
        sat_round_t                  r;
        q_max = (OUT_DECIM_W+1)'((64'sd1 <<< (BIT_PREC-1)) - 64'sd1);
        t     = {x[OUT_DECIM_W-1], x} + ((OUT_DECIM_W+1)'(1) << (OUT_FRAC_SHIFT-1));
        q     = t >>> OUT_FRAC_SHIFT;
        r.sat = 1'b0;
        r.val = q[BIT_PREC-1:0];
        if (q > q_max) begin
            r.sat = 1'b1;
            r.val = {1'b0, {(BIT_PREC-1){1'b1}}};
        end else if (q < ~q_max) begin
            r.sat = 1'b1;
            r.val = {1'b1, {(BIT_PREC-1){1'b0}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Small synchronous FIFO with a show-ahead head. Pointers carry a wrap bit.
// When empty the head shows the last popped word (0 after reset).
module fir_out_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] last_pop;
    logic         wr_en;
    logic         rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign head  = empty ? last_pop : mem[rd_ptr[AW-1:0]];

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer update and hold of the last word handed out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_pop <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr   <= rd_ptr + (AW+1)'(1);
                last_pop <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/fir_out_decim.sv
// FIR output stage: keep one of every DECIM strobed samples, round and
// saturate to OUT_W bits, buffer in a FIFO and hand out on valid/ready.
// Optional macro FIR_OUT_DECIM_SATCNT_EN adds a 16-bit saturation counter.
module fir_out_decim
    import fir_pkg::*;
#(
    parameter int IN_W       = OUT_DECIM_W,
    parameter int OUT_W      = BIT_PREC,
    parameter int FRAC_SHIFT = OUT_FRAC_SHIFT,
    parameter int DECIM      = DECIM_DEFAULT,
    parameter int FIFO_DEPTH = OUT_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fir_en,
    input  logic signed [IN_W-1:0]  in_wave,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat,
    output logic                    ovf,
    input  logic                    clr_ovf
`ifdef FIR_OUT_DECIM_SATCNT_EN
    ,
    output logic [15:0]             sat_cnt
`endif
);
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0]       PH_LAST = PH_W'(DECIM - 1);
    localparam logic signed [IN_W:0]  RND     = (IN_W+1)'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [IN_W:0]  Q_MAX   = (IN_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [IN_W:0]  Q_MIN   = ~Q_MAX;
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [PH_W-1:0]         phase;
    logic                    sel;
    logic signed [IN_W:0]    t_rnd;
    logic signed [IN_W:0]    q_shf;
    logic signed [OUT_W-1:0] q_val;
    logic                    q_sat;
    logic                    s1_valid;
    logic signed [OUT_W-1:0] s1_data;
    logic                    s1_sat;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;

    assign sel       = fir_en && (phase == '0);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign sat       = s1_sat;

    // Round half up, drop the fraction, then clip to the output range.
    always_comb begin
        t_rnd = {in_wave[IN_W-1], in_wave} + RND;
        q_shf = t_rnd >>> FRAC_SHIFT;
        q_val = q_shf[OUT_W-1:0];
        q_sat = 1'b0;
        if (q_shf > Q_MAX) begin
            q_val = OUT_MAX;
            q_sat = 1'b1;
        end else if (q_shf < Q_MIN) begin
            q_val = OUT_MIN;
            q_sat = 1'b1;
        end
    end

    // Decimation phase, advanced only by the sample strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (fir_en) begin
            phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
        end
    end

    // Stage 1: capture the quantized selected sample; sat is qualified here
    // so it pulses exactly in the cycle the FIFO write is attempted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_sat   <= 1'b0;
        end else begin
            s1_valid <= sel;
            s1_sat   <= sel && q_sat;
            if (sel) begin
                s1_data <= q_val;
            end
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (s1_valid && fifo_full && !pop) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

`ifdef FIR_OUT_DECIM_SATCNT_EN
    // Saturation event counter; a pulse coinciding with a clear restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (s1_sat) begin
            if (clr_ovf) begin
                sat_cnt <= 16'd1;
            end else if (sat_cnt != 16'hFFFF) begin
                sat_cnt <= sat_cnt + 16'd1;
            end
        end else if (clr_ovf) begin
            sat_cnt <= '0;
        end
    end
`endif

    fir_out_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s1_valid),
        .push_data (s1_data),
        .pop       (pop),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_fir_out_decim.sv
// Bench for fir_out_decim: queue-level reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_fir_out_decim;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              fir_en    = 1'b0;
    logic signed [38:0] in_wave  = '0;
    logic              out_ready = 1'b0;
    logic              clr_ovf   = 1'b0;
    logic signed [15:0] out_data;
    logic              out_valid;
    logic              sat;
    logic              ovf;
`ifdef FIR_OUT_DECIM_SATCNT_EN
    logic [15:0]       sat_cnt;
`endif

    fir_out_decim dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fir_en    (fir_en),
        .in_wave   (in_wave),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
`ifdef FIR_OUT_DECIM_SATCNT_EN
        ,
        .sat_cnt   (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int     m_phase = 0;
    bit     m_pend_v = 0;
    bit     m_pend_s = 0;
    longint m_pend_d = 0;
    longint m_q[$];
    longint m_last = 0;
    bit     m_ovf = 0;
    longint got[$];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void quant(input longint x, output longint v, output bit s);
        longint t;
        longint q;
        t = x + 64'sd16384;
        if (t >= 0) q = t / 32768;
        else        q = -((-t + 32767) / 32768);
        s = 1'b0;
        v = q;
        if (q > 32767) begin
            v = 32767;
            s = 1'b1;
        end else if (q < -32768) begin
            v = -32768;
            s = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        m_phase  = 0;
        m_pend_v = 0;
        m_pend_s = 0;
        m_pend_d = 0;
        m_q.delete();
        m_last   = 0;
        m_ovf    = 0;
    endfunction

    // One clock edge of the model, using the inputs present at that edge.
    function automatic void model_step();
        bit  popped;
        bit  dropped;
        int  n;
        n       = m_q.size();
        popped  = (n > 0) && out_ready;
        dropped = 0;
        if (popped) m_last = m_q.pop_front();
        if (m_pend_v) begin
            if (n < 4 || popped) m_q.push_back(m_pend_d);
            else                 dropped = 1;
        end
        if (dropped)      m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
        if (fir_en && m_phase == 0) begin
            m_pend_v = 1;
            quant(longint'(in_wave), m_pend_d, m_pend_s);
        end else begin
            m_pend_v = 0;
            m_pend_s = 0;
        end
        if (fir_en) m_phase = (m_phase + 1) % 4;
    endfunction

    task automatic cycle();
        if (out_valid && out_ready) got.push_back(longint'(out_data));
        if (!rst_n) model_reset();
        else        model_step();
        @(posedge clk);
        #1;
        check("out_valid", longint'(out_valid), longint'(m_q.size() > 0));
        check("out_data",  longint'(out_data),  (m_q.size() > 0) ? m_q[0] : m_last);
        check("sat",       longint'(sat),       longint'(m_pend_v && m_pend_s));
        check("ovf",       longint'(ovf),       longint'(m_ovf));
    endtask

    // One selected sample followed by three non-selected strobes, then idle.
    task automatic one_sample(input string nm, input longint v, input longint exp_d, input longint exp_s);
        fir_en  = 1'b1;
        in_wave = 39'(v);
        cycle();
        check({nm, " sat"}, longint'(sat), exp_s);
        in_wave = '0;
        cycle();
        check({nm, " data"}, longint'(out_data), exp_d);
        cycle();
        cycle();
        fir_en = 1'b0;
        cycle();
        cycle();
    endtask

    initial begin
        repeat (3) cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cycle();
        check("reset out_valid", longint'(out_valid), 0);
        check("reset out_data",  longint'(out_data),  0);
        check("reset ovf",       longint'(ovf),       0);

        one_sample("round 3",    64'sd3 * 32768,        3,      0);
        one_sample("round +half", 64'sd16384,           1,      0);
        one_sample("round -half", -64'sd16384,          0,      0);
        one_sample("round -1",   -64'sd16385,          -1,      0);
        one_sample("sat pos",    64'sd40000 * 32768,    32767,  1);
        one_sample("sat neg",    -64'sd40000 * 32768,  -32768,  1);

        // decimation with a continuous strobe
        got.delete();
        for (int k = 0; k < 12; k++) begin
            fir_en  = 1'b1;
            in_wave = 39'(longint'(k) * 32768);
            cycle();
            if (k == 0) check("decim latency n+1", longint'(out_valid), 0);
            if (k == 1) begin
                check("decim latency n+2", longint'(out_valid), 1);
                check("decim first",       longint'(out_data),  0);
            end
        end
        fir_en = 1'b0;
        repeat (4) cycle();
        check("decim count", longint'(got.size()), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) check("decim value", got[i], longint'(i) * 4);

        // overflow with the consumer stalled; clear coincides with the last drop
        out_ready = 1'b0;
        got.delete();
        for (int i = 0; i < 24; i++) begin
            fir_en  = 1'b1;
            in_wave = 39'(longint'(10 + i / 4) * 32768);
            clr_ovf = (i == 21);
            cycle();
            clr_ovf = 1'b0;
            if (i == 21) check("ovf set beats clear", longint'(ovf), 1);
        end
        fir_en = 1'b0;
        cycle();
        cycle();
        check("ovf sticky",    longint'(ovf),       1);
        check("ovf head",      longint'(out_data),  10);
        check("ovf out_valid", longint'(out_valid), 1);
        out_ready = 1'b1;
        repeat (6) cycle();
        check("ovf drain count", longint'(got.size()), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("ovf drain value", got[i], 10 + i);
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;
        check("ovf cleared", longint'(ovf), 0);

        // full FIFO with push and pop on the same edge
        out_ready = 1'b0;
        got.delete();
        for (int i = 0; i < 17; i++) begin
            fir_en  = 1'b1;
            in_wave = 39'(longint'(20 + i / 4) * 32768);
            cycle();
        end
        fir_en    = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("full push+pop ovf",  longint'(ovf),       0);
        check("full push+pop head", longint'(out_data),  21);
        repeat (6) cycle();
        check("full drain count", longint'(got.size()), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) check("full drain value", got[i], 20 + i);

        // reset with three samples queued and the phase mid-count
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fir_en  = 1'b1;
            in_wave = '0;
            cycle();
        end
        for (int i = 0; i < 9; i++) begin
            fir_en  = 1'b1;
            in_wave = 39'(longint'(30 + i / 4) * 32768);
            cycle();
        end
        fir_en = 1'b0;
        cycle();
        cycle();
        check("queued before reset", longint'(out_data), 30);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async reset out_valid", longint'(out_valid), 0);
        check("async reset out_data",  longint'(out_data),  0);
        cycle();
        cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        fir_en    = 1'b1;
        in_wave   = 39'(64'sd7 * 32768);
        cycle();
        fir_en  = 1'b0;
        in_wave = '0;
        cycle();
        check("post reset valid", longint'(out_valid), 1);
        check("post reset data",  longint'(out_data),  7);
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
